slave_mem_responder: RTL
========================

# slave_mem_responder

Synthesizable slave-side responder for the crossbar slave port (req/addr/cmd/wdata → ack/resp/rdata). It terminates one crossbar slave port with a word-addressed register-file memory. Writes are acknowledged in a single cycle; reads return data after a fixed, parameterised latency. It replaces behavioural slave models in system benches and serves as on-chip scratch memory.

## Interface
- ADDR_W, default 8: memory index width; depth = 2**ADDR_W 32-bit words; legal 1..12.
- READ_LATENCY, default 4: cycles from ack rise to the resp pulse; legal 1..15.
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  reset: asynchronous, active-high.
- req_i  input  1  request; held with addr/cmd/wdata stable by the master until ack is seen.
- addr_i  input  31  word address; only addr_i[ADDR_W-1:0] is used, upper bits ignored (aliasing).
- cmd_i  input  1  1 = write, 0 = read.
- wdata_i  input  32  write data.
- ack_o  output  1  request accepted.
- resp_o  output  1  read data valid, one-cycle pulse.
- rdata_o  output  32  read data; holds the last returned value.

## Operation
- States: IDLE, WR_ACK, RD_ACK, RD_WAIT, RELEASE.
- IDLE: if req_i=1, capture addr index, cmd and wdata.
  - cmd=1 → WR_ACK.
  - cmd=0 → RD_ACK.
  - With req_i=0, stay in IDLE.
- WR_ACK (1 cycle): ack_o=1; mem[idx] <= captured wdata at the end of this cycle. Next state is RELEASE if req_i=1, else IDLE.
- RD_ACK: ack_o=1; load the latency counter with READ_LATENCY-1; go to RD_WAIT.
  - When READ_LATENCY=1, skip RD_WAIT: resp is produced in the next cycle.
- RD_WAIT: ack_o stays 1; the counter decrements each cycle.
  - When the counter reaches 0, the next cycle drives resp_o=1 and rdata_o=mem[idx]. This is the resp cycle, still in RD_WAIT.
  - After the resp cycle, ack_o and resp_o drop together. Next state is RELEASE if req_i=1, else IDLE.
- RELEASE: ack_o=0; wait for req_i=0, then return to IDLE.
  - This state prevents re-accepting a request the master has not yet dropped.
  - The master must therefore drive req_i=0 for at least one cycle between transactions.
- Inputs are captured at acceptance only. Changes to addr/cmd/wdata after acceptance are ignored.
- Read data comes from the memory array at the resp cycle. A write can never overlap a pending read, because only one transaction is outstanding.
- Memory contents are not cleared by reset and are preserved across reset. Contents after power-up are undefined.
- Counter width is 4 bits.

## Timing
- Reset values: ack_o=0, resp_o=0, rdata_o=0, state IDLE, counter 0.
- Reset asserted mid-transaction:
  - All outputs go to 0 immediately (asynchronously).
  - A write whose WR_ACK cycle has not completed is dropped.
  - A pending read is abandoned with no resp.
- Write: req_i sampled high in IDLE at edge N. ack_o is high for exactly cycle N+1. Memory is updated at edge N+2.
- Read: req_i sampled high at edge N.
  - ack_o rises in cycle N+1.
  - resp_o is high only in cycle N+1+READ_LATENCY, with rdata_o valid in that cycle.
  - ack_o falls with resp_o, at edge N+2+READ_LATENCY.
- Minimum spacing for back-to-back writes: req at N, ack at N+1, master drops req at N+2 (RELEASE), next req accepted at N+3.
- req_i dropped by the master before ack (protocol violation): the captured transaction still completes normally.

## Test plan
- Reset, then write addr=0x05, wdata=0xDEADBEEF → ack_o high exactly 1 cycle, one cycle after req; resp_o stays 0.
- Read addr=0x05 with READ_LATENCY=4 → ack_o high cycles N+1..N+5; resp_o=1 only at N+5 with rdata_o=0xDEADBEEF; ack_o/resp_o low at N+6.
- Aliasing: write addr=0x105 wdata=0x12345678 (ADDR_W=8), then read addr=0x05 → rdata_o=0x12345678.
- Master holds req_i high 3 cycles after ack → exactly one ack; no second acceptance until req_i has been low for 1 cycle. Then write 0x0A=0x1, 0x0B=0x2 and read both back → 0x1, 0x2.
- Assert rst_i during RD_WAIT (2 cycles after ack) → ack_o=resp_o=rdata_o=0 immediately, no resp pulse. After release, a read of 0x05 returns 0xDEADBEEF (memory preserved).
- READ_LATENCY=1 build: read → ack at N+1, resp plus correct rdata at N+2; a write followed by a read of the same address returns the new data.

Source files
------------

// File: rtl/slave_mem_responder.sv
// Crossbar slave-port responder backed by a word-addressed 32-bit register-file memory.
// Writes are acked for one cycle; read data returns READ_LATENCY cycles after ack rises.
module slave_mem_responder #(
    parameter int ADDR_W       = 8,
    parameter int READ_LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [30:0] addr_i,
    input  logic        cmd_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic        resp_o,
    output logic [31:0] rdata_o
);
    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ACK,
        RD_ACK,
        RD_WAIT,
        RELEASE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              resp_q, resp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem_q [DEPTH];

    // Upper address bits alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[30:ADDR_W];

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    idx_d   = addr_i[ADDR_W-1:0];
                    wdata_d = wdata_i;
                    state_d = cmd_i ? WR_ACK : RD_ACK;
                end
            end
            WR_ACK:  state_d = req_i ? RELEASE : IDLE;
            RD_ACK: begin
                cnt_d   = CNT_LOAD;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // A zero count in RD_WAIT is the resp cycle; leave right after it.
                if (cnt_q == 4'd0) begin
                    state_d = req_i ? RELEASE : IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RELEASE: begin
                if (!req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ack_d   = (state_d == WR_ACK) || (state_d == RD_ACK) || (state_d == RD_WAIT);
        resp_d  = (state_d == RD_WAIT) && (cnt_d == 4'd0);
        rdata_d = resp_d ? mem_q[idx_q] : rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the array is deliberately not reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (state_q == WR_ACK) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o   = ack_q;
    assign resp_o  = resp_q;
    assign rdata_o = rdata_q;
endmodule
